// File: rtl/l2_arbiter.sv
// Purpose: two-way round-robin arbiter placing I-cache or D-cache line requests onto the single L2 port.
// Latency: L2 request asserts the cycle after grant; requester resp pulses the cycle after l2_resp (3 cycles minimum).
// Backpressure: one transaction in flight; the losing requester holds its request until a later IDLE grants it.
module l2_arbiter (
  input  logic         clk,
  input  logic         rst,
  // I-cache side
  input  logic [31:0]  i_address,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  // D-cache side
  input  logic [31:0]  d_address,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  // L2 side
  output logic [31:0]  l2_address,
  output logic         l2_read,
  output logic         l2_write,
  output logic [255:0] l2_wdata,
  input  logic [255:0] l2_rdata,
  input  logic         l2_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Set when the most recent grant went to the D-cache; breaks ties in favour of the other side.
  logic last_d;
  // Operation latched at a D grant: 1 = write-back, 0 = line read.
  logic d_is_write;

  logic d_req;
  logic grant_i;
  logic grant_d;

  // Round-robin pick: a lone requester always wins; on contention the side not served last wins.
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req & (~i_read | ~last_d);
    grant_i = i_read & ~grant_d;
  end

  // Next-state: IDLE grants, SERVE waits for L2, RESP lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = SERVE_D;
        end else if (grant_i) begin
          state_nxt = SERVE_I;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          state_nxt = RESP_I;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          state_nxt = RESP_D;
        end
      end
      RESP_I:  state_nxt = IDLE;
      RESP_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from the state so read and write can never overlap and are low outside SERVE.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (state)
      SERVE_I: l2_read  = 1'b1;
      SERVE_D: begin
        l2_read  = ~d_is_write;
        l2_write = d_is_write;
      end
      RESP_I:  i_resp   = 1'b1;
      RESP_D:  d_resp   = 1'b1;
      default: ;
    endcase
  end

  // State register; a reset abandons any in-flight L2 request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the winner's address, write line and operation at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d     <= 1'b0;
      l2_address <= 32'd0;
      l2_wdata   <= 256'd0;
      d_is_write <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        l2_address <= d_address;
        l2_wdata   <= d_wdata;
        d_is_write <= d_write;
        last_d     <= 1'b1;
      end else if (grant_i) begin
        l2_address <= i_address;
        last_d     <= 1'b0;
      end
    end
  end

  // Return line registers; a D write-back completes without touching d_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata <= 256'd0;
      d_rdata <= 256'd0;
    end else begin
      if ((state == SERVE_I) && l2_resp) begin
        i_rdata <= l2_rdata;
      end
      if ((state == SERVE_D) && l2_resp && !d_is_write) begin
        d_rdata <= l2_rdata;
      end
    end
  end

endmodule
